// File: rtl/prog_ram_pkg.sv
// Shared types and default sizes for the program/data RAM.
package prog_ram_pkg;
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD} state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
endpackage

// File: rtl/prog_ram_if.sv
// CPU access port and program-loader stream of prog_ram, bundled as one interface.
interface prog_ram_if
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              mar_load;
  logic [ADDR_W-1:0] addr_in;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              prog_start;
  logic [DATA_W-1:0] prog_data;
  logic              prog_valid;
  logic              prog_last;
  logic              prog_ready;
  logic              prog_done;
  logic              busy;

  // Loader handshake: a beat transfers on every rising edge where prog_valid
  // and prog_ready are both high; prog_data/prog_last are meaningful only then.
  modport master (
    output mar_load, addr_in, wr_en, din, rd_en,
    output prog_start, prog_data, prog_valid, prog_last,
    input  dout, dout_valid, prog_ready, prog_done, busy
  );

  modport slave (
    input  mar_load, addr_in, wr_en, din, rd_en,
    input  prog_start, prog_data, prog_valid, prog_last,
    output dout, dout_valid, prog_ready, prog_done, busy
  );
endinterface

// File: rtl/prog_ram_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one read-first registered read port.
module ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read samples the pre-write contents, so a same-address write is seen next cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/prog_ram.sv
// Program/data RAM with MAR, post-reset clear sweep and streaming program loader.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  prog_ram_if.slave  bus,
  output state_t     o_state
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr, w_ptr_next;
  logic [ADDR_W-1:0] r_mar, w_mar_next;
  logic [ADDR_W-1:0] w_eff_addr, w_waddr;
  logic [DATA_W-1:0] w_wdata, w_rdata;
  logic              w_we, w_re, w_done_next;
  logic              r_rd_valid, r_has_data, r_done;

  assign w_eff_addr = bus.mar_load ? bus.addr_in : r_mar;

  always_comb begin
    w_next      = r_state;
    w_ptr_next  = r_ptr;
    w_mar_next  = r_mar;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_waddr     = w_eff_addr;
    w_wdata     = bus.din;
    w_done_next = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_we       = 1'b1;
        w_waddr    = r_ptr;
        w_wdata    = CLEAR_VAL;
        w_ptr_next = r_ptr + 1'b1;
        if (r_ptr == LAST_ADDR) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        // A load request wins the cycle; any CPU access alongside it is dropped.
        if (bus.prog_start) begin
          w_ptr_next = '0;
          w_next     = ST_LOAD;
        end else begin
          if (bus.mar_load) w_mar_next = bus.addr_in;
          w_we = bus.wr_en;
          w_re = bus.rd_en;
        end
      end
      ST_LOAD: begin
        if (bus.prog_valid) begin
          w_we       = 1'b1;
          w_waddr    = r_ptr;
          w_wdata    = bus.prog_data;
          w_ptr_next = r_ptr + 1'b1;
          if (bus.prog_last) begin
            w_next      = ST_IDLE;
            w_done_next = 1'b1;
          end
        end
      end
      default: w_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_ptr      <= '0;
      r_mar      <= '0;
      r_rd_valid <= 1'b0;
      r_has_data <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ptr      <= w_ptr_next;
      r_mar      <= w_mar_next;
      r_rd_valid <= w_re;
      r_done     <= w_done_next;
      if (w_re) r_has_data <= 1'b1;
    end
  end

  // The array's read register has no reset; dout reads as zero until the first read lands.
  ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_we    (w_we & ~rst),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re & ~rst),
    .i_raddr (w_eff_addr),
    .o_rdata (w_rdata)
  );

  assign bus.dout       = r_has_data ? w_rdata : '0;
  assign bus.dout_valid = r_rd_valid;
  assign bus.prog_ready = (r_state == ST_LOAD);
  assign bus.prog_done  = r_done;
  assign bus.busy       = (r_state != ST_IDLE);
  assign o_state        = r_state;
endmodule

// File: tb/tb_prog_ram.sv
// Randomised and directed bench for prog_ram against a behavioural memory model.
module tb_prog_ram;
  import prog_ram_pkg::*;

  localparam int DW = 8, AW = 4, DEPTH = 16;
  localparam int BDW = 16, BAW = 6, BDEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  prog_ram_if #(.DATA_W(DW),  .ADDR_W(AW))  bus();
  prog_ram_if #(.DATA_W(BDW), .ADDR_W(BAW)) bus2();
  state_t dbg_state, dbg_state2;

  prog_ram #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .o_state(dbg_state));

  prog_ram #(.DATA_W(BDW), .ADDR_W(BAW), .CLEAR_VAL(16'hFFFF)) u_big (
    .clk(clk), .rst(rst2), .bus(bus2.slave), .o_state(dbg_state2));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            m_clear_left = DEPTH;
  bit            m_loading = 0;
  int            m_lptr = 0;
  int            m_mar = 0;
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 0;
  bit            m_done = 0;
  bit            m_live = 0;

  always @(posedge clk) begin : model
    int ea;
    m_live = 1;
    if (rst) begin
      m_clear_left = DEPTH;
      m_loading    = 0;
      m_lptr       = 0;
      m_mar        = 0;
      m_dout       = '0;
      m_valid      = 0;
      m_done       = 0;
      exp_q.delete();
    end else begin
      m_valid = 0;
      m_done  = 0;
      if (m_clear_left > 0) begin
        m_mem[DEPTH - m_clear_left] = '0;
        m_clear_left--;
      end else if (m_loading) begin
        if (bus.prog_valid) begin
          m_mem[m_lptr] = bus.prog_data;
          m_lptr = (m_lptr + 1) % DEPTH;
          if (bus.prog_last) begin
            m_loading = 0;
            m_done    = 1;
          end
        end
      end else if (bus.prog_start) begin
        m_loading = 1;
        m_lptr    = 0;
      end else begin
        ea = bus.mar_load ? int'(bus.addr_in) : m_mar;
        if (bus.mar_load) m_mar = int'(bus.addr_in);
        if (bus.rd_en) begin
          m_dout  = m_mem[ea];
          m_valid = 1;
          exp_q.push_back(m_mem[ea]);
        end
        if (bus.wr_en) m_mem[ea] = bus.din;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("busy",       32'(bus.busy),       32'((m_clear_left > 0) || m_loading));
      check("prog_ready", 32'(bus.prog_ready), 32'(m_loading));
      check("prog_done",  32'(bus.prog_done),  32'(m_done));
      check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
      check("dout_hold",  32'(bus.dout),       32'(m_dout));
      if (m_valid && exp_q.size() > 0) check("read_data", 32'(bus.dout), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.mar_load = 0; bus.addr_in = '0; bus.wr_en = 0; bus.din = '0; bus.rd_en = 0;
    bus.prog_start = 0; bus.prog_data = '0; bus.prog_valid = 0; bus.prog_last = 0;
    bus2.mar_load = 0; bus2.addr_in = '0; bus2.wr_en = 0; bus2.din = '0; bus2.rd_en = 0;
    bus2.prog_start = 0; bus2.prog_data = '0; bus2.prog_valid = 0; bus2.prog_last = 0;
  endtask

  task automatic cpu(input bit ml, input int a, input bit we, input int d, input bit re);
    bus.mar_load = ml; bus.addr_in = AW'(a); bus.wr_en = we; bus.din = DW'(d); bus.rd_en = re;
    cyc();
    idle_in();
  endtask

  task automatic read_chk(input int a, input int exp, input string name);
    cpu(1, a, 0, 0, 1);
    @(negedge clk);
    check(name, 32'(bus.dout), 32'(exp));
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    cyc();
  endtask

  task automatic load(input logic [DW-1:0] data[$], input int gap_at);
    bus.prog_start = 1;
    cyc();
    bus.prog_start = 0;
    for (int i = 0; i < data.size(); i++) begin
      if (i == gap_at) begin
        bus.prog_valid = 0;
        cyc();
      end
      bus.prog_valid = 1;
      bus.prog_data  = data[i];
      bus.prog_last  = (i == data.size() - 1);
      cyc();
    end
    bus.prog_valid = 0;
    bus.prog_last  = 0;
    @(negedge clk);
    check("done_pulse", 32'(bus.prog_done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [DW-1:0] q[$];
    idle_in();
    repeat (3) cyc();
    rst = 0;
    wait_idle(4 * DEPTH, n);
    check("clear_cycles", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) read_chk(i, 0, "post_clear");

    // MAR bypass write, then read through MAR, then read-first collision
    cyc();
    cpu(1, 5, 1, 8'hA5, 0);
    cpu(0, 0, 0, 0, 1);
    @(negedge clk);
    check("mar_read", 32'(bus.dout), 32'hA5);
    cpu(0, 0, 1, 8'h3C, 1);
    @(negedge clk);
    check("read_first", 32'(bus.dout), 32'hA5);
    read_chk(5, 8'h3C, "after_write");

    // three-beat load with an idle gap
    q = '{8'h11, 8'h22, 8'h33};
    cyc();
    load(q, 1);
    check("model_m0", 32'(m_mem[0]), 32'h11);
    check("model_m2", 32'(m_mem[2]), 32'h33);
    read_chk(0, 8'h11, "load3_0");
    read_chk(1, 8'h22, "load3_1");
    read_chk(2, 8'h33, "load3_2");

    // 18 beats wrap past the top address
    q.delete();
    for (int i = 0; i < 18; i++) q.push_back(DW'(i));
    cyc();
    load(q, -1);
    read_chk(0, 8'h10, "wrap_0");
    read_chk(1, 8'h11, "wrap_1");
    for (int i = 2; i < DEPTH; i++) read_chk(i, i, "wrap_n");

    // reset lands on the beat for address 7
    cyc();
    bus.prog_start = 1;
    cyc();
    bus.prog_start = 0;
    for (int i = 0; i < 7; i++) begin
      bus.prog_valid = 1; bus.prog_data = DW'(8'h80 + i);
      cyc();
    end
    bus.prog_data = 8'h87;
    rst = 1;
    cyc();
    check("ready_drop", 32'(bus.prog_ready), 32'd0);
    idle_in();
    rst = 0;
    wait_idle(4 * DEPTH, n);
    check("reclear_cycles", 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) read_chk(i, 0, "reclear");

    // randomised traffic
    for (int it = 0; it < 150; it++) begin
      cyc();
      if ($urandom_range(0, 9) < 8) begin
        cpu(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 1'($urandom_range(0, 1)),
            $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      end else begin
        q.delete();
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) q.push_back(DW'($urandom_range(0, 255)));
        load(q, $urandom_range(0, 25));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      cpu(1, i, 0, 0, 1);
    end
    repeat (2) cyc();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    // wide/deep configuration with an all-ones clear value
    rst2 = 0;
    n = 0;
    for (int i = 0; i < 4 * BDEPTH; i++) begin
      @(negedge clk);
      if (!bus2.busy) break;
      n++;
    end
    check("big_clear_cycles", 32'(n), 32'(BDEPTH));
    cyc();
    bus2.mar_load = 1; bus2.addr_in = 6'd63; bus2.rd_en = 1;
    cyc();
    idle_in();
    @(negedge clk);
    check("big_rd63", 32'(bus2.dout), 32'hFFFF);
    check("big_valid", 32'(bus2.dout_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prog_ram.md
# prog_ram

Parametrised program/data RAM for the 8-bit CPU datapath. It generalises the fixed 16×8 bus RAM in four ways:
- configurable width and depth;
- separate in/out data ports instead of a tristate bus;
- an internal memory-address register (MAR);
- a hardware sweep that clears memory after reset, plus a byte-streaming program loader with valid/ready handshake.

It sits between the CPU bus controller and the program-entry front end.

## Interface
Parameters:
- DATA_W, 8, data word width
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W (localparam)
- CLEAR_VAL, 0, word written to every location by the post-reset sweep

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- mar_load  in  1  latch addr_in into MAR
- addr_in  in  ADDR_W  address for MAR
- wr_en  in  1  write din to mem[eff_addr]
- din  in  DATA_W  write data
- rd_en  in  1  read mem[eff_addr] into dout
- dout  out  DATA_W  registered read data
- dout_valid  out  1  dout updated this cycle (1-cycle pulse per read)
- prog_start  in  1  begin streaming load at address 0
- prog_data  in  DATA_W  load beat data
- prog_valid  in  1  load beat valid
- prog_last  in  1  marks final load beat
- prog_ready  out  1  loader accepts beats
- prog_done  out  1  one-cycle pulse after final beat is written
- busy  out  1  high in CLEAR or LOAD

## Operation
- The block has three states: CLEAR, IDLE and LOAD.
- **Reset (rst=1):**
  - state←CLEAR, ptr←0, MAR←0.
  - dout←0, dout_valid←0, prog_ready←0, prog_done←0, busy←1.
  - Memory contents are not reset directly.
- **CLEAR:**
  - Each cycle writes mem[ptr]←CLEAR_VAL, then ptr++.
  - After writing DEPTH-1, go to IDLE (DEPTH cycles total after rst falls).
  - All CPU and prog inputs are ignored.
- **IDLE, CPU access:**
  - eff_addr = mar_load ? addr_in : MAR (bypass). MAR←addr_in when mar_load=1.
  - wr_en: mem[eff_addr]←din.
  - rd_en: dout←mem[eff_addr], dout_valid←1 next cycle.
  - rd_en and wr_en to the same address in the same cycle: read-first, so dout returns the old word.
  - dout holds its value when there is no read.
- **IDLE, prog_start:**
  - prog_start has priority over wr_en/rd_en in the same cycle; those are dropped.
  - Transition: ptr←0, state←LOAD.
- **LOAD:**
  - prog_ready=1.
  - Each beat with prog_valid & prog_ready writes mem[ptr]←prog_data, then ptr++.
  - ptr wraps from DEPTH-1 to 0 and overwrites earlier beats; no error is flagged.
  - An accepted beat with prog_last=1 moves to IDLE and pulses prog_done on the next cycle.
  - CPU inputs and repeat prog_start are ignored.
- rst asserted mid-LOAD or mid-CLEAR abandons the operation and restarts CLEAR from address 0.

## Timing
- Read latency: 1 cycle (rd_en at edge N → dout/dout_valid valid after edge N+1).
- Write takes effect at the edge where wr_en is sampled; a read in the next cycle sees the new data.
- Post-reset: busy=1 for exactly DEPTH cycles after rst deasserts, then drops to 0.
- prog_ready rises the cycle after prog_start is accepted and falls the cycle after the last beat.
- prog_done is high for exactly 1 cycle, concurrent with busy falling.
- Throughput: one beat per cycle while prog_valid is held.

## Structure
- Package prog_ram_pkg:
  - state enum {ST_CLEAR, ST_IDLE, ST_LOAD};
  - default DATA_W/ADDR_W constants.
- Sub-module ram_array:
  - DEPTH×DATA_W;
  - one synchronous write port, one synchronous read-first read port;
  - no reset.
  - Top-level muxes the write address/data from CLEAR sweep, loader or CPU.

## Test plan
- Reset with default params → busy=1 for 16 cycles, then 0; reads of addresses 0..15 all return 0x00 with dout_valid one cycle after each rd_en.
- mar_load addr 5 + wr_en din=0xA5, then rd_en next cycle → dout=0xA5 one cycle later; same-cycle rd_en+wr_en 0x3C to addr 5 returns 0xA5, a following read returns 0x3C.
- prog_start, then stream 0x11,0x22,0x33 (last on 0x33) with one idle prog_valid gap → mem[0..2]=11,22,33; prog_done pulses once; busy falls with it.
- Stream 18 beats (ADDR_W=4) values 0x00..0x11 → mem[0]=0x10, mem[1]=0x11, mem[2..15]=0x02..0x0F (wrap).
- Assert rst during a LOAD beat at address 7 → prog_ready drops next cycle; CLEAR sweep reruns for 16 cycles; all locations read 0x00.
- ADDR_W=6, DATA_W=16, CLEAR_VAL=0xFFFF → busy for 64 cycles; read addr 63 returns 0xFFFF.
